maze_probe: RTL and testbench

MAZE_PROBE -- requirements
Module: maze_probe

---
 rtl/maze_probe.sv | 171 +++++++++++++++++
 tb/tb_maze_probe.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/maze_probe.sv
// rtl/maze_probe.sv - eight-point maze collision probe around a player box (option: MAZE_PROBE_TUNNEL_EN)
module maze_probe #(
    parameter int TILE_SHIFT   = 4,
    parameter int MAP_W        = 32,
    parameter int MAP_H        = 32,
    parameter int TUNNEL_Y_MIN = 195,
    parameter int TUNNEL_Y_MAX = 223
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       start,
    input  logic [9:0] BallX,
    input  logic [9:0] BallY,
    input  logic [9:0] BallS,
    output logic [9:0] rom_addr,
    input  logic [4:0] rom_data,
    output logic [4:0] mapL,
    output logic [4:0] mapR,
    output logic [4:0] mapT,
    output logic [4:0] mapB,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {S_IDLE, S_PROBE, S_LAST} state_t;

    localparam logic [10:0] X_LIM = 11'(MAP_W << TILE_SHIFT);
    localparam logic [10:0] Y_LIM = 11'(MAP_H << TILE_SHIFT);

    state_t      state_q, state_d;
    logic [2:0]  idx_q, idx_d;
    logic [9:0]  x_q, y_q, s_q;
    logic [4:0]  code_q [0:6];
    logic        prev_oor_q;
    logic        done_q;
    logic [4:0]  map_l_q, map_r_q, map_t_q, map_b_q;

    logic [10:0] xs, ys, ss;
    logic [10:0] xm1, xp1, xm, xp, ym1, yp1, ym, yp;
    logic [10:0] px, py, col, row;
    logic        oor;
    logic [4:0]  fill, code_eff;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= S_IDLE;
            idx_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_PROBE;
                    idx_d   = 3'd0;
                end
            end
            S_PROBE: begin
                if (idx_q == 3'd7) state_d = S_LAST;
                else               idx_d   = idx_q + 3'd1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy     = (state_q != S_IDLE);
        rom_addr = 10'd0;
        if (state_q == S_PROBE && !oor)
            rom_addr = 10'(row * 11'(MAP_W) + col);
    end

    // Probe points use 11-bit wrapping arithmetic; a set sign bit means off the map.
    assign xs  = {1'b0, x_q};
    assign ys  = {1'b0, y_q};
    assign ss  = {1'b0, s_q};
    assign xm  = xs - ss;
    assign xp  = xs + ss;
    assign ym  = ys - ss;
    assign yp  = ys + ss;
    assign xm1 = xm - 11'd1;
    assign xp1 = xp + 11'd1;
    assign ym1 = ym - 11'd1;
    assign yp1 = yp + 11'd1;

    always_comb begin
        px = xm1;
        py = ym;
        case (idx_q)
            3'd0: begin px = xm1; py = ym;  end
            3'd1: begin px = xm1; py = yp;  end
            3'd2: begin px = xp1; py = ym;  end
            3'd3: begin px = xp1; py = yp;  end
            3'd4: begin px = xm;  py = ym1; end
            3'd5: begin px = xp;  py = ym1; end
            3'd6: begin px = xm;  py = yp1; end
            3'd7: begin px = xp;  py = yp1; end
        endcase
    end

    assign oor = px[10] | py[10] | (px >= X_LIM) | (py >= Y_LIM);
    assign col = px >> TILE_SHIFT;
    assign row = py >> TILE_SHIFT;

`ifdef MAZE_PROBE_TUNNEL_EN
    localparam logic [9:0] TY_MIN = 10'(TUNNEL_Y_MIN);
    localparam logic [9:0] TY_MAX = 10'(TUNNEL_Y_MAX);
    logic prev_lr_q;
    logic in_tunnel;

    assign in_tunnel = (y_q >= TY_MIN) && (y_q <= TY_MAX);
    // Horizontal probes leaving the map inside the tunnel band wrap to open floor.
    assign fill      = (prev_lr_q && in_tunnel) ? 5'd0 : 5'h1F;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset)                  prev_lr_q <= 1'b0;
        else if (state_q == S_PROBE) prev_lr_q <= ~idx_q[2];
        else                        prev_lr_q <= 1'b0;
    end
`else
    assign fill = 5'd0;
`endif

    assign code_eff = prev_oor_q ? fill : rom_data;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            x_q        <= 10'd0;
            y_q        <= 10'd0;
            s_q        <= 10'd0;
            prev_oor_q <= 1'b0;
            done_q     <= 1'b0;
            map_l_q    <= 5'd0;
            map_r_q    <= 5'd0;
            map_t_q    <= 5'd0;
            map_b_q    <= 5'd0;
            for (int i = 0; i < 7; i++) code_q[i] <= 5'd0;
        end else begin
            done_q <= (state_q == S_LAST);
            if (state_q == S_IDLE && start) begin
                x_q <= BallX;
                y_q <= BallY;
                s_q <= BallS;
            end
            if (state_q == S_PROBE) begin
                prev_oor_q <= oor;
                if (idx_q != 3'd0) code_q[idx_q - 3'd1] <= code_eff;
            end
            // Probe 7 arrives in LAST, so the bottom pair reads it straight from the ROM path.
            if (state_q == S_LAST) begin
                map_l_q <= (code_q[0] != 5'd0) ? code_q[0] : code_q[1];
                map_r_q <= (code_q[2] != 5'd0) ? code_q[2] : code_q[3];
                map_t_q <= (code_q[4] != 5'd0) ? code_q[4] : code_q[5];
                map_b_q <= (code_q[6] != 5'd0) ? code_q[6] : code_eff;
            end
        end
    end

    assign mapL = map_l_q;
    assign mapR = map_r_q;
    assign mapT = map_t_q;
    assign mapB = map_b_q;
    assign done = done_q;

endmodule

// File: tb/tb_maze_probe.sv
// tb/tb_maze_probe.sv - randomized and directed self-checking bench for maze_probe
module tb_maze_probe;

    localparam int TS = 4;
    localparam int MW = 32;
    localparam int MH = 32;
`ifdef MAZE_PROBE_TUNNEL_EN
    localparam int TYMIN = 195;
    localparam int TYMAX = 223;
`endif

    logic       Clk = 1'b0;
    logic       Reset = 1'b0;
    logic       start = 1'b0;
    logic [9:0] BallX = 10'd0, BallY = 10'd0, BallS = 10'd0;
    logic [9:0] rom_addr;
    logic [4:0] rom_data = 5'd0;
    logic [4:0] mapL, mapR, mapT, mapB;
    logic       busy, done;

    logic [4:0] rom [0:1023];

    int n_cmp = 0;
    int n_bad = 0;
    bit checking = 1'b0;

    always #5 Clk = ~Clk;

    maze_probe dut (
        .Clk(Clk), .Reset(Reset), .start(start),
        .BallX(BallX), .BallY(BallY), .BallS(BallS),
        .rom_addr(rom_addr), .rom_data(rom_data),
        .mapL(mapL), .mapR(mapR), .mapT(mapT), .mapB(mapB),
        .busy(busy), .done(done)
    );

    always @(posedge Clk) rom_data <= rom[rom_addr];

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference model: phase counts cycles since an accepted start.
    int ph = 0;
    int sx = 0, sy = 0, ss = 0;
    logic [4:0] ml = 0, mr = 0, mt = 0, mb = 0;
    logic md = 1'b0;

    function automatic int wrap11(input int v);
        int w;
        w = v & 2047;
        return (w >= 1024) ? w - 2048 : w;
    endfunction

    function automatic void probe_pt(input int k, output int px, output int py);
        case (k)
            0: begin px = sx - ss - 1; py = sy - ss;     end
            1: begin px = sx - ss - 1; py = sy + ss;     end
            2: begin px = sx + ss + 1; py = sy - ss;     end
            3: begin px = sx + ss + 1; py = sy + ss;     end
            4: begin px = sx - ss;     py = sy - ss - 1; end
            5: begin px = sx + ss;     py = sy - ss - 1; end
            6: begin px = sx - ss;     py = sy + ss + 1; end
            default: begin px = sx + ss; py = sy + ss + 1; end
        endcase
        px = wrap11(px);
        py = wrap11(py);
    endfunction

    function automatic bit is_oor(input int k);
        int px, py;
        probe_pt(k, px, py);
        return (px < 0) || (py < 0) || (px >= (MW << TS)) || (py >= (MH << TS));
    endfunction

    function automatic int exp_addr(input int k);
        int px, py;
        probe_pt(k, px, py);
        if (is_oor(k)) return 0;
        return (py >> TS) * MW + (px >> TS);
    endfunction

    function automatic logic [4:0] exp_code(input int k);
        if (is_oor(k)) begin
`ifdef MAZE_PROBE_TUNNEL_EN
            return (k < 4 && sy >= TYMIN && sy <= TYMAX) ? 5'd0 : 5'h1F;
`else
            return 5'd0;
`endif
        end
        return rom[exp_addr(k)];
    endfunction

    function automatic logic [4:0] first(input logic [4:0] a, input logic [4:0] b);
        return (a != 5'd0) ? a : b;
    endfunction

    always @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            ph = 0; sx = 0; sy = 0; ss = 0;
            ml = 0; mr = 0; mt = 0; mb = 0; md = 1'b0;
        end else begin
            md = 1'b0;
            if (ph == 9) begin
                ml = first(exp_code(0), exp_code(1));
                mr = first(exp_code(2), exp_code(3));
                mt = first(exp_code(4), exp_code(5));
                mb = first(exp_code(6), exp_code(7));
                md = 1'b1;
                ph = 0;
            end else if (ph != 0) begin
                ph++;
            end else if (start) begin
                sx = int'(BallX); sy = int'(BallY); ss = int'(BallS);
                ph = 1;
            end
        end
    end

    always @(negedge Clk) begin
        if (checking) begin
            check("busy", 32'(busy), 32'(ph != 0));
            check("done", 32'(done), 32'(md));
            check("rom_addr", 32'(rom_addr), (ph >= 1 && ph <= 8) ? exp_addr(ph - 1) : 0);
            check("mapL", 32'(mapL), 32'(ml));
            check("mapR", 32'(mapR), 32'(mr));
            check("mapT", 32'(mapT), 32'(mt));
            check("mapB", 32'(mapB), 32'(mb));
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic fire(input int x, input int y, input int s);
        BallX = 10'(x); BallY = 10'(y); BallS = 10'(s);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic run(input int x, input int y, input int s);
        fire(x, y, s);
        repeat (9) tick();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int ea [8];
        int pulses;
        int rc;
        int g;
        ea = '{491, 523, 493, 525, 459, 461, 523, 525};
        for (int a = 0; a < 1024; a++) rom[a] = 5'd0;

        Reset = 1'b1;
        repeat (2) tick();
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_addr", 32'(rom_addr), 0);
        check("rst_maps", 32'({mapL, mapR, mapT, mapB}), 0);
        Reset = 1'b0;
        checking = 1'b1;
        tick();

        fire(202, 253, 13);
        for (int k = 0; k < 8; k++) begin
            check($sformatf("addr_seq%0d", k), 32'(rom_addr), ea[k]);
            if (k < 7) tick();
        end
        tick();
        check("last_busy", 32'(busy), 1);
        check("last_done", 32'(done), 0);
        tick();
        check("end_done", 32'(done), 1);
        check("end_busy", 32'(busy), 0);
        check("zero_maps", 32'({mapL, mapR, mapT, mapB}), 0);
        tick();
        check("done_once", 32'(done), 0);

        rom[523] = 5'd3;
        run(202, 253, 13);
        check("one_L", 32'(mapL), 3);
        check("one_B", 32'(mapB), 3);
        check("one_R", 32'(mapR), 0);
        check("one_T", 32'(mapT), 0);
        rom[491] = 5'd1;
        rom[523] = 5'd2;
        run(202, 253, 13);
        check("b2b_done", 32'(done), 1);
        check("firstwins_L", 32'(mapL), 1);
        check("firstwins_B", 32'(mapB), 2);

        rom[491] = 5'd0;
        rom[523] = 5'd0;
        fire(202, 253, 13);
        for (int c = 1; c <= 9; c++) begin
            check($sformatf("hold_L_c%0d", c), 32'(mapL), 1);
            start = (c == 3 || c == 5);
            tick();
            start = 1'b0;
        end
        check("upd_L", 32'(mapL), 0);
        check("upd_done", 32'(done), 1);
        tick();
        check("no_restart", 32'(busy), 0);

        fire(5, 253, 13);
        check("oor_addr_c1", 32'(rom_addr), 0);
        tick();
        check("oor_addr_c2", 32'(rom_addr), 0);
        repeat (8) tick();
`ifdef MAZE_PROBE_TUNNEL_EN
        check("oor_L", 32'(mapL), 31);
`else
        check("oor_L", 32'(mapL), 0);
`endif
        run(5, 209, 13);
        check("tunnel_L", 32'(mapL), 0);

        rom[491] = 5'd7;
        run(202, 253, 13);
        check("pre_rst_L", 32'(mapL), 7);
        fire(202, 253, 13);
        repeat (3) tick();
        Reset = 1'b1;
        #1;
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_L", 32'(mapL), 0);
        tick();
        Reset = 1'b0;
        pulses = 0;
        repeat (12) begin
            tick();
            if (done) pulses++;
        end
        check("rst_no_done", 32'(pulses), 0);
        run(202, 253, 13);
        check("post_rst_L", 32'(mapL), 7);
        check("post_rst_done", 32'(done), 1);

        for (int it = 0; it < 300; it++) begin
            g = 0;
            while (busy && g < 30) begin
                tick();
                g++;
            end
            if (busy) begin
                n_cmp++;
                n_bad++;
                $display("FAIL idle_wait: busy still %0d after %0d cycles, required 0", busy, g);
            end
            if ($urandom % 4 == 0)
                for (int a = 0; a < 1024; a++) rom[a] = ($urandom % 2 == 1) ? 5'd0 : 5'($urandom);
            repeat ($urandom % 3) tick();
            case ($urandom % 4)
                0: fire(int'($urandom % 1024), int'($urandom % 1024), int'($urandom % 1024));
                1: fire(int'($urandom_range(0, 40)), int'($urandom_range(188, 230)), int'($urandom % 24));
                default: fire(int'($urandom_range(0, 540)), int'($urandom_range(0, 540)), int'($urandom % 40));
            endcase
            rc = ($urandom % 20 == 0) ? int'($urandom_range(1, 9)) : 0;
            for (int c = 1; c <= 9; c++) begin
                BallX = 10'($urandom);
                BallY = 10'($urandom);
                start = ($urandom % 4 == 0);
                if (c == rc) begin
                    start = 1'b0;
                    Reset = 1'b1;
                end
                tick();
                Reset = 1'b0;
                start = 1'b0;
            end
        end
        repeat (12) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
